// File: rtl/jtkcpu_cen_if.sv
// Enable/handshake bundle between the jtkcpu clock-enable generator and the CPU side.
// The CPU side drives the memory request and ready signals; the generator drives the enables.
interface jtkcpu_cen_if #(
   parameter int LW = 4
);
   logic          cs;
   logic          dtack;
   logic          cen;
   logic          cen2;
   logic          wait_st;
   logic [LW-1:0] lost;

   modport master (output cs, output dtack, input cen, input cen2, input wait_st, input lost);
   modport slave  (input cs, input dtack, output cen, output cen2, output wait_st, output lost);
endinterface

// File: rtl/jtkcpu_cen.sv
// Fractional-rate cen/cen2 generator for jtkcpu with dtack wait-state stretching
// and optional catch-up of ticks lost while the CPU was held.
module jtkcpu_cen #(
   parameter int CW      = 10,
   parameter int NUM     = 1,
   parameter int DEN     = 4,
   parameter int RECOVER = 1,
   parameter int LW      = 4
)(
   input  logic        clk,
   input  logic        rst,
   jtkcpu_cen_if.slave bus
);

   typedef enum logic [1:0] {S_PH0, S_PH1, S_WAIT} state_t;

   localparam logic [CW-1:0] NUM_C    = CW'(NUM);
   localparam logic [CW-1:0] DEN_C    = CW'(DEN);
   localparam logic [LW-1:0] LOST_MAX = '1;

   state_t        r_state, w_state_nx;
   logic [CW-1:0] r_acc, w_sum, w_acc_nx;
   logic [LW-1:0] r_lost, w_lost_nx;
   logic          r_cen, r_cen2, r_wait;
   logic          w_cen_nx, w_cen2_nx;
   logic          w_nat, w_rec, w_tick, w_block;

   // Exact fractional accumulator: remainder carried, so no long-run drift
   assign w_sum    = r_acc + NUM_C;
   assign w_nat    = (w_sum >= DEN_C);
   assign w_acc_nx = w_nat ? (w_sum - DEN_C) : w_sum;

   assign w_block  = bus.cs & ~bus.dtack;
   // Catch-up ticks only fill clocks that are idle and not adjacent to a previous pulse
   assign w_rec    = (RECOVER != 0) && (r_lost != '0) && (r_state != S_WAIT)
                     && !w_nat && !r_cen2;
   assign w_tick   = w_nat | w_rec;

   always_comb begin
      w_state_nx = r_state;
      w_lost_nx  = r_lost;
      w_cen_nx   = 1'b0;
      w_cen2_nx  = 1'b0;
      if (w_tick) begin
         unique case (r_state)
            S_PH0: begin
               w_cen2_nx  = 1'b1;
               w_state_nx = S_PH1;
            end
            S_PH1: begin
               if (w_block) begin
                  w_state_nx = S_WAIT;
               end else begin
                  w_cen_nx   = 1'b1;
                  w_cen2_nx  = 1'b1;
                  w_state_nx = S_PH0;
               end
            end
            S_WAIT: begin
               if (w_block) begin
                  if (r_lost != LOST_MAX) w_lost_nx = r_lost + 1'b1;
               end else begin
                  w_cen_nx   = 1'b1;
                  w_cen2_nx  = 1'b1;
                  w_state_nx = S_PH0;
               end
            end
            default: w_state_nx = S_PH0;
         endcase
         // Only a catch-up tick that actually reached the CPU pays back a lost tick
         if (w_rec && w_cen2_nx) w_lost_nx = r_lost - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_PH0;
         r_acc   <= '0;
         r_lost  <= '0;
         r_cen   <= 1'b0;
         r_cen2  <= 1'b0;
         r_wait  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_acc   <= w_acc_nx;
         r_lost  <= w_lost_nx;
         r_cen   <= w_cen_nx;
         r_cen2  <= w_cen2_nx;
         r_wait  <= (w_state_nx == S_WAIT);
      end
   end

   assign bus.cen     = r_cen;
   assign bus.cen2    = r_cen2;
   assign bus.wait_st = r_wait;
   assign bus.lost    = r_lost;

endmodule

// File: tb/tb_jtkcpu_cen.sv
// Bench for jtkcpu_cen: four parameterisations run side by side against a tick-count model.
module tb_jtkcpu_cen;

   logic clk;
   logic rst;

   jtkcpu_cen_if #(.LW(4)) b0 ();
   jtkcpu_cen_if #(.LW(4)) b1 ();
   jtkcpu_cen_if #(.LW(4)) b2 ();
   jtkcpu_cen_if #(.LW(2)) b3 ();

   // u0: 1/4 recover, u1: 3/8 recover, u2: 1/4 no recover, u3: 1/4 recover with 2-bit lost
   jtkcpu_cen #(.CW(10), .NUM(1), .DEN(4), .RECOVER(1), .LW(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
   jtkcpu_cen #(.CW(10), .NUM(3), .DEN(8), .RECOVER(1), .LW(4)) u1 (.clk(clk), .rst(rst), .bus(b1));
   jtkcpu_cen #(.CW(10), .NUM(1), .DEN(4), .RECOVER(0), .LW(4)) u2 (.clk(clk), .rst(rst), .bus(b2));
   jtkcpu_cen #(.CW(10), .NUM(1), .DEN(4), .RECOVER(1), .LW(2)) u3 (.clk(clk), .rst(rst), .bus(b3));

   int P_NUM[4]  = '{1, 3, 1, 1};
   int P_DEN[4]  = '{4, 8, 4, 4};
   int P_REC[4]  = '{1, 1, 0, 1};
   int P_LMAX[4] = '{15, 15, 15, 3};

   logic t_cs[4];
   logic t_dtack[4];
   assign b0.cs = t_cs[0]; assign b0.dtack = t_dtack[0];
   assign b1.cs = t_cs[1]; assign b1.dtack = t_dtack[1];
   assign b2.cs = t_cs[2]; assign b2.dtack = t_dtack[2];
   assign b3.cs = t_cs[3]; assign b3.dtack = t_dtack[3];

   logic [3:0] o_cen, o_cen2, o_wait;
   int         o_lost[4];
   assign o_cen  = {b3.cen, b2.cen, b1.cen, b0.cen};
   assign o_cen2 = {b3.cen2, b2.cen2, b1.cen2, b0.cen2};
   assign o_wait = {b3.wait_st, b2.wait_st, b1.wait_st, b0.wait_st};
   assign o_lost[0] = int'(b0.lost);
   assign o_lost[1] = int'(b1.lost);
   assign o_lost[2] = int'(b2.lost);
   assign o_lost[3] = int'(b3.lost);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: natural ticks come from the clock count since reset (floor(n*NUM/DEN) steps)
   int m_n[4];
   int m_lost[4];
   bit m_ph[4], m_pend[4], m_cen[4], m_cen2[4];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int u = 0; u < 4; u++) begin
            m_n[u]    <= 0;
            m_lost[u] <= 0;
            m_ph[u]   <= 1'b0;
            m_pend[u] <= 1'b0;
            m_cen[u]  <= 1'b0;
            m_cen2[u] <= 1'b0;
         end
      end else begin
         for (int u = 0; u < 4; u++) begin
            int n1, lst;
            bit nat, rec, blk, ph, pend, c, c2;
            n1   = m_n[u] + 1;
            nat  = ((n1 * P_NUM[u]) / P_DEN[u]) != (((n1 - 1) * P_NUM[u]) / P_DEN[u]);
            rec  = (P_REC[u] != 0) && (m_lost[u] > 0) && !m_pend[u] && !nat && !m_cen2[u];
            blk  = t_cs[u] && !t_dtack[u];
            ph   = m_ph[u];
            pend = m_pend[u];
            lst  = m_lost[u];
            c    = 1'b0;
            c2   = 1'b0;
            if (nat || rec) begin
               if (pend) begin
                  if (blk) begin
                     if (lst < P_LMAX[u]) lst = lst + 1;
                  end else begin
                     c = 1'b1; c2 = 1'b1; pend = 1'b0; ph = 1'b0;
                  end
               end else if (ph && blk) begin
                  pend = 1'b1;
               end else begin
                  c2 = 1'b1; c = ph; ph = !ph;
                  if (rec) lst = lst - 1;
               end
            end
            m_n[u]    <= n1;
            m_lost[u] <= lst;
            m_ph[u]   <= ph;
            m_pend[u] <= pend;
            m_cen[u]  <= c;
            m_cen2[u] <= c2;
         end
      end
   end

   int vecs = 0;
   int errs = 0;
   int ec   = 0;
   int c_cen[4], c_cen2[4], adj[4], coinc[4];
   bit prev_c2[4];
   int first0;
   int rec3;

   task automatic check(input string name, input int u, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s u%0d edge %0d: got %0d, want %0d", name, u, ec, act, exp);
      end
   endtask

   task automatic clr();
      for (int u = 0; u < 4; u++) begin
         c_cen[u] = 0; c_cen2[u] = 0; adj[u] = 0; coinc[u] = 0; prev_c2[u] = 1'b0;
      end
      first0 = 0;
      rec3   = 0;
   endtask

   // One clock: advance, then compare every DUT output against the model on the falling edge
   task automatic step();
      @(posedge clk);
      ec++;
      @(negedge clk);
      for (int u = 0; u < 4; u++) begin
         check("cen",     u, int'(o_cen[u]),  int'(m_cen[u]));
         check("cen2",    u, int'(o_cen2[u]), int'(m_cen2[u]));
         check("wait_st", u, int'(o_wait[u]), int'(m_pend[u]));
         check("lost",    u, o_lost[u],       m_lost[u]);
         c_cen[u]  += int'(o_cen[u]);
         c_cen2[u] += int'(o_cen2[u]);
         if (o_cen2[u] && prev_c2[u]) adj[u]++;
         if (o_cen[u] && !o_cen2[u]) coinc[u]++;
         prev_c2[u] = o_cen2[u];
      end
      if (o_cen2[0] && first0 == 0) first0 = ec;
      if (o_cen2[3] && (ec % 4) != 0) rec3++;
   endtask

   initial begin
      rst = 1'b0;
      for (int u = 0; u < 4; u++) begin
         t_cs[u] = 1'b0; t_dtack[u] = 1'b1;
      end
      clr();
      repeat (3) step();
      check("rst_cen",  0, int'(o_cen[0]),  0);
      check("rst_cen2", 0, int'(o_cen2[0]), 0);
      check("rst_lost", 0, o_lost[0],       0);

      // Free-running rates, no memory waits
      rst = 1'b1; ec = 0; clr();
      repeat (64) step();
      check("cnt_cen2_64",  0, c_cen2[0], 16);
      check("cnt_cen_64",   0, c_cen[0],  8);
      check("first_cen2",   0, first0,    4);
      check("cen_no_cen2",  0, coinc[0],  0);
      repeat (736) step();
      check("cnt_cen2_800", 1, c_cen2[1], 300);
      check("cnt_cen_800",  1, c_cen[1],  150);
      check("adjacent",     1, adj[1],    0);
      check("cen_no_cen2",  1, coinc[1],  0);

      // Wait states with and without recovery, plus lost saturation
      rst = 1'b0;
      repeat (2) step();
      rst = 1'b1; ec = 0; clr();
      for (int k = 1; k <= 100; k++) begin
         step();
         if (ec == 5) begin
            t_cs[0] = 1'b1; t_dtack[0] = 1'b0;
            t_cs[2] = 1'b1; t_dtack[2] = 1'b0;
            t_cs[3] = 1'b1; t_dtack[3] = 1'b0;
         end
         if (ec == 8)  check("wait_first", 0, int'(o_wait[0]), 1);
         if (ec == 16) begin
            check("lost_peak",    0, o_lost[0], 2);
            check("lost_peak_r0", 2, o_lost[2], 2);
         end
         if (ec == 17) begin t_dtack[0] = 1'b1; t_dtack[2] = 1'b1; end
         if (ec == 20) begin
            check("resume_cen", 0, int'(o_cen[0]), 1);
            t_cs[0] = 1'b0; t_cs[2] = 1'b0;
         end
         if (ec == 22) check("rec_pulse", 0, int'(o_cen2[0]), 1);
         if (ec == 26) check("lost_repaid", 0, o_lost[0], 0);
         if (ec == 44) check("lost_sat", 3, o_lost[3], 3);
         if (ec == 45) t_dtack[3] = 1'b1;
         if (ec == 50) t_cs[3] = 1'b0;
      end
      check("lost_kept_r0", 2, o_lost[2], 2);
      check("lost_sat_end", 3, o_lost[3], 0);
      check("rec_ticks",    3, rec3,      3);
      check("adjacent",     0, adj[0],    0);

      // Asynchronous reset in the middle of a stretch
      rst = 1'b0;
      repeat (2) step();
      rst = 1'b1; ec = 0; clr();
      for (int k = 1; k <= 21; k++) begin
         step();
         if (ec == 5) begin t_cs[0] = 1'b1; t_dtack[0] = 1'b0; end
         if (ec == 20) begin
            check("pre_rst_lost", 0, o_lost[0],       3);
            check("pre_rst_wait", 0, int'(o_wait[0]), 1);
         end
      end
      #2 rst = 1'b0;
      #1;
      check("arst_cen",  0, int'(o_cen[0]),  0);
      check("arst_cen2", 0, int'(o_cen2[0]), 0);
      check("arst_wait", 0, int'(o_wait[0]), 0);
      check("arst_lost", 0, o_lost[0],       0);
      repeat (2) step();
      t_cs[0] = 1'b0; t_dtack[0] = 1'b1;
      rst = 1'b1; ec = 0; clr();
      repeat (8) step();
      check("restart_cen2", 0, first0,   4);
      check("restart_cnt",  0, c_cen[0], 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
